inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port Run  in  1  start request; sampled only in IDLE.
REQ-004 SHALL have port Ld_En  in  1  instruction-memory write enable; honoured only in IDLE.
REQ-005 SHALL have port Ld_Addr  in  8  word index for load.
REQ-006 SHALL have port Ld_Data  in  32  instruction word for load.
REQ-007 SHALL have port Branch  in  1  branch control from decode stage.
REQ-008 SHALL have port Jump  in  1  jump control from decode stage.
REQ-009 SHALL have port Zero  in  1  ALU equality flag for the current instruction.
REQ-010 SHALL have port PC  out  32  current program counter.
REQ-011 SHALL have port Instr  out  32  current instruction word.
REQ-012 SHALL have port OP_Code  out  6  Instr[31:26], feeds the decode stage.
REQ-013 SHALL have ports rs, rt, rd, shamt, funct, imm16  out  5/5/5/5/6/16  Instr[25:21], [20:16], [15:11], [10:6], [5:0], [15:0].
REQ-014 SHALL have port Halted  out  1  high while in HALT.

Function
REQ-015 SHALL contain a 256 x 32 instruction memory, read combinationally at index PC[9:2]; PC[31:10] ignored (aliasing).
REQ-016 SHALL implement three states: IDLE, RUN, HALT.
REQ-017 IDLE: PC held; Instr driven 32'h0; a rising edge with Ld_En=1 writes Ld_Data to mem[Ld_Addr].
REQ-018 IDLE -> RUN on a rising edge with Run=1; PC stays 0 on that edge, so the first RUN cycle fetches mem[0].
REQ-019 Ld_En=1 and Run=1 on the same IDLE edge: write SHALL complete and transition SHALL occur.
REQ-020 RUN: Instr = mem[PC[9:2]]; PC updates every rising edge to next-PC (REQ-021..023).
REQ-021 Jump=1: next-PC = {PC4[31:28], Instr[25:0], 2'b00}, where PC4 = PC + 4.
REQ-022 Jump=0, Branch=1, Zero=1: next-PC = PC4 + ({{14{imm16[15]}}, imm16, 2'b00}).
REQ-023 otherwise: next-PC = PC4; Jump SHALL take priority over Branch.
REQ-024 All PC arithmetic modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0; PC[1:0] always 00.
REQ-025 Branch/Jump/Zero SHALL be treated as don't-care outside RUN.
REQ-026 RUN -> HALT on the edge where the fetched Instr equals 32'hFFFFFFFF (halt sentinel); PC SHALL NOT advance on that edge.
REQ-027 HALT: PC frozen; Instr driven 32'h0; Halted=1; Ld_En and Run ignored; exit only via reset.
REQ-028 Ld_En in RUN or HALT SHALL NOT modify memory.
REQ-029 Decoded-field outputs SHALL always be pure slices of the Instr output (0 in IDLE/HALT).

Reset
REQ-030 reset=1 at a rising edge: state -> IDLE, PC -> 0, Halted -> 0, Instr -> 0; SHALL take priority over Run, Ld_En and next-PC.
REQ-031 Memory contents SHALL NOT be cleared by reset; reset during RUN restarts from IDLE with the program intact.
REQ-032 Reset asserted on the same edge as Ld_En in IDLE: the write SHALL still occur.

Verification
REQ-033 Load mem[0..2] = 8C010004, 00000020, FFFFFFFF; pulse Run -> PC sequence 0, 4, 8; at 8, Halted=1 next edge; PC stays 8 indefinitely.
REQ-034 RUN at PC=0x10 with Instr=08000040, Jump=1 -> next PC = 0x100; Jump=1 and Branch=1, Zero=1 together -> still 0x100.
REQ-035 PC=0x20, imm16=FFFE, Branch=1, Zero=1 -> PC=0x1C; same with Zero=0 -> PC=0x24.
REQ-036 Ld_En=1, Ld_Addr=5, Ld_Data=DEADBEEF while in RUN -> mem[5] unchanged (fetch PC=0x14 shows original word).
REQ-037 Reset mid-RUN at PC=0x40 -> next cycle PC=0, IDLE, Instr=0; Run again -> mem[0] refetched unchanged.
REQ-038 Force PC to 0x400 via jump -> fetches mem[0] (aliasing); PC=0xFFFFFFFC sequential -> next PC=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: 256-word instruction memory, program counter and
// IDLE/RUN/HALT sequencing with jump, branch and halt-sentinel handling.
module inst_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        Run,
    input  logic        Ld_En,
    input  logic [7:0]  Ld_Addr,
    input  logic [31:0] Ld_Data,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [5:0]  OP_Code,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic        Halted
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] PC_STEP   = 32'd4;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] br_off;
    logic [DATA_W-1:0] fetch_word;

    // Memory is only writable while idle; it is never cleared by reset.
    always_ff @(posedge clk) begin
        if (Ld_En && (state == IDLE)) begin
            mem[Ld_Addr] <= Ld_Data;
        end
    end

    // Word index ignores PC[31:10], so addresses alias every 1 KiB.
    assign fetch_word = mem[PC[9:2]];
    assign Instr      = (state == RUN) ? fetch_word : '0;

    assign OP_Code = Instr[31:26];
    assign rs      = Instr[25:21];
    assign rt      = Instr[20:16];
    assign rd      = Instr[15:11];
    assign shamt   = Instr[10:6];
    assign funct   = Instr[5:0];
    assign imm16   = Instr[15:0];

    // State, PC and halt flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            PC     <= '0;
            Halted <= 1'b0;
        end else begin
            state  <= state_next;
            PC     <= pc_next;
            Halted <= (state_next == HALT);
        end
    end

    // Next-state and next-PC selection; jump outranks branch.
    always_comb begin
        state_next = state;
        pc_next    = PC;
        pc4        = PC + PC_STEP;
        br_off     = {{14{imm16[15]}}, imm16, 2'b00};
        case (state)
            IDLE: begin
                if (Run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (Instr == HALT_WORD) begin
                    state_next = HALT;
                end else if (Jump) begin
                    pc_next = {pc4[31:28], Instr[25:0], 2'b00};
                end else if (Branch && Zero) begin
                    pc_next = pc4 + br_off;
                end else begin
                    pc_next = pc4;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
                pc_next    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected PC/Instr/Halted per cycle are
// queued as stimulus is driven and compared after the following clock edge.
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic        Run;
    logic        Ld_En;
    logic [7:0]  Ld_Addr;
    logic [31:0] Ld_Data;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [5:0]  OP_Code;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        Halted;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    inst_fetch dut (
        .clk     (clk),
        .reset   (reset),
        .Run     (Run),
        .Ld_En   (Ld_En),
        .Ld_Addr (Ld_Addr),
        .Ld_Data (Ld_Data),
        .Branch  (Branch),
        .Jump    (Jump),
        .Zero    (Zero),
        .PC      (PC),
        .Instr   (Instr),
        .OP_Code (OP_Code),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm16   (imm16),
        .Halted  (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Queue the expected post-edge state, clock once, then pop and compare.
    task automatic cyc(input string tag, input logic [31:0] pc, input logic [31:0] instr, input logic halted);
        exp_t e;
        e.tag = tag; e.pc = pc; e.instr = instr; e.halted = halted;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".pc"},     PC,             e.pc);
        check({e.tag, ".instr"},  Instr,          e.instr);
        check({e.tag, ".halted"}, 32'(Halted),    32'(e.halted));
        check({e.tag, ".op"},     32'(OP_Code),   32'(e.instr[31:26]));
        check({e.tag, ".rs"},     32'(rs),        32'(e.instr[25:21]));
        check({e.tag, ".rt"},     32'(rt),        32'(e.instr[20:16]));
        check({e.tag, ".rd"},     32'(rd),        32'(e.instr[15:11]));
        check({e.tag, ".shamt"},  32'(shamt),     32'(e.instr[10:6]));
        check({e.tag, ".funct"},  32'(funct),     32'(e.instr[5:0]));
        check({e.tag, ".imm16"},  32'(imm16),     32'(e.instr[15:0]));
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        Ld_En = 1'b1; Ld_Addr = a; Ld_Data = d;
        cyc("load", 32'h0, 32'h0, 1'b0);
        Ld_En = 1'b0;
    endtask

    task automatic ctl(input logic j, input logic b, input logic z);
        Jump = j; Branch = b; Zero = z;
    endtask

    initial begin
        reset = 1'b1; Run = 1'b0; Ld_En = 1'b0; Ld_Addr = '0; Ld_Data = '0;
        ctl(1'b0, 1'b0, 1'b0);

        // Reset state and basic run to the halt sentinel.
        cyc("reset", 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        load(8'd0, 32'h8C01_0004);
        load(8'd1, 32'h0000_0020);
        load(8'd2, 32'hFFFF_FFFF);
        cyc("idle_hold", 32'h0, 32'h0, 1'b0);
        Run = 1'b1;
        cyc("a_run0", 32'h0, 32'h8C01_0004, 1'b0);
        Run = 1'b0;
        cyc("a_pc4", 32'h4, 32'h0000_0020, 1'b0);
        cyc("a_pc8", 32'h8, 32'hFFFF_FFFF, 1'b0);
        cyc("a_halt", 32'h8, 32'h0, 1'b1);
        Run = 1'b1; Ld_En = 1'b1; Ld_Addr = 8'd0; Ld_Data = 32'h0;
        ctl(1'b1, 1'b1, 1'b1);
        cyc("a_halt_hold1", 32'h8, 32'h0, 1'b1);
        cyc("a_halt_hold2", 32'h8, 32'h0, 1'b1);
        Run = 1'b0; Ld_En = 1'b0;
        ctl(1'b0, 1'b0, 1'b0);

        // Reset from HALT, then reset coinciding with an IDLE load.
        reset = 1'b1;
        cyc("b_reset", 32'h0, 32'h0, 1'b0);
        Ld_En = 1'b1; Ld_Addr = 8'd3; Ld_Data = 32'h0;
        cyc("b_reset_ld", 32'h0, 32'h0, 1'b0);
        reset = 1'b0; Ld_En = 1'b0;
        load(8'd1, 32'h0800_0010);
        ctl(1'b1, 1'b1, 1'b1);
        load(8'd2, 32'h0000_0000);
        ctl(1'b0, 1'b0, 1'b0);
        load(8'd4, 32'h0800_0040);
        load(8'd5, 32'h0800_0100);
        load(8'd7, 32'h0800_0005);
        load(8'd8, 32'h1000_FFFE);
        load(8'd9, 32'h0800_0008);
        load(8'd16, 32'h0000_0000);
        load(8'd64, 32'h0800_0008);

        // Control-flow run: jump, branch taken/not taken, blocked RUN write.
        Run = 1'b1;
        cyc("b_run0", 32'h0, 32'h8C01_0004, 1'b0);
        Run = 1'b0; Ld_En = 1'b1; Ld_Addr = 8'd5; Ld_Data = 32'hDEAD_BEEF;
        cyc("b_pc4", 32'h4, 32'h0800_0010, 1'b0);
        Ld_En = 1'b0;
        cyc("b_pc8", 32'h8, 32'h0, 1'b0);
        cyc("b_pcc", 32'hC, 32'h0, 1'b0);
        cyc("b_pc10", 32'h10, 32'h0800_0040, 1'b0);
        ctl(1'b1, 1'b1, 1'b1);
        cyc("b_jump_prio", 32'h100, 32'h0800_0008, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        cyc("b_jump20", 32'h20, 32'h1000_FFFE, 1'b0);
        ctl(1'b0, 1'b1, 1'b0);
        cyc("b_br_nottaken", 32'h24, 32'h0800_0008, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        cyc("b_jump20b", 32'h20, 32'h1000_FFFE, 1'b0);
        ctl(1'b0, 1'b1, 1'b1);
        cyc("b_br_taken", 32'h1C, 32'h0800_0005, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        cyc("b_mem5_intact", 32'h14, 32'h0800_0100, 1'b0);
        cyc("b_alias400", 32'h400, 32'h8C01_0004, 1'b0);
        ctl(1'b0, 1'b0, 1'b0);
        cyc("b_pc404", 32'h404, 32'h0800_0010, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        cyc("b_pc40", 32'h40, 32'h0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0);

        // Reset mid-RUN, program preserved.
        reset = 1'b1; Run = 1'b1;
        cyc("b_midrun_reset", 32'h0, 32'h0, 1'b0);
        reset = 1'b0; Run = 1'b0;
        cyc("b_idle_after", 32'h0, 32'h0, 1'b0);
        Run = 1'b1;
        cyc("b_refetch0", 32'h0, 32'h8C01_0004, 1'b0);
        Run = 1'b0;

        // Run and load on the same edge, then negative branch and PC wrap.
        reset = 1'b1;
        cyc("c_reset", 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        load(8'd0, 32'h1000_FFFE);
        Run = 1'b1; Ld_En = 1'b1; Ld_Addr = 8'd255; Ld_Data = 32'h1234_5678;
        cyc("c_run_ld", 32'h0, 32'h1000_FFFE, 1'b0);
        Run = 1'b0; Ld_En = 1'b0;
        ctl(1'b0, 1'b1, 1'b1);
        cyc("c_br_neg", 32'hFFFF_FFFC, 32'h1234_5678, 1'b0);
        ctl(1'b0, 1'b0, 1'b0);
        cyc("c_wrap", 32'h0, 32'h1000_FFFE, 1'b0);
        cyc("c_seq4", 32'h4, 32'h0800_0010, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
